// File: rtl/arf054b256e1r1w0cbbeheaa4acw_wr_arb.sv
// Write-port arbiter and sequencer for the 256 x 54 1R1W latch register file.
// Round-robin between requesters A and B. The winning address and data are
// registered so they stay stable through the clk-low latch transparency window.
// Optional write-to-read forwarding: define ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN.
module arf054b256e1r1w0cbbeheaa4acw_wr_arb #(
   parameter int unsigned DWIDTH = 54,
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned CWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_vld,
   output logic              a_rdy,
   input  logic [AWIDTH-1:0] a_addr,
   input  logic [DWIDTH-1:0] a_data,
   input  logic              b_vld,
   output logic              b_rdy,
   input  logic [AWIDTH-1:0] b_addr,
   input  logic [DWIDTH-1:0] b_data,
   input  logic              wr_stall,
   output logic              wr_en,
   output logic [AWIDTH-1:0] wr_addr,
   output logic [DWIDTH-1:0] wr_data,
   input  logic [AWIDTH-1:0] rd_addr,
   input  logic [DWIDTH-1:0] rd_data_arr,
   output logic [DWIDTH-1:0] rd_data,
   output logic [CWIDTH-1:0] wr_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [CWIDTH-1:0] CNT_MAX = '1;

   state_t state;
   logic   last_b;
   logic   grant;

   // Combinational grant: last_b=1 means B won last time, so A has priority.
   // Gated by rst_n so neither side is acknowledged while reset is held.
   always_comb begin
      a_rdy = rst_n & ~wr_stall & a_vld & (last_b | ~b_vld);
      b_rdy = rst_n & ~wr_stall & b_vld & (~last_b | ~a_vld);
      grant = a_rdy | b_rdy;
   end

   // Sequencer: capture the winner, move the pointer only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last_b  <= 1'b1;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         case (state)
            IDLE:    state <= grant ? WRITE : IDLE;
            WRITE:   state <= grant ? WRITE : IDLE;
            default: state <= IDLE;
         endcase
         if (grant) begin
            wr_addr <= a_rdy ? a_addr : b_addr;
            wr_data <= a_rdy ? a_data : b_data;
            last_b  <= b_rdy;
         end
      end
   end

   // The strobe is the state flop itself, so reset clears it asynchronously.
   assign wr_en = (state == WRITE);

   // Saturating count of completed writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt <= '0;
      end else if (wr_en && (wr_cnt != CNT_MAX)) begin
         wr_cnt <= wr_cnt + CWIDTH'(1);
      end
   end

`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
   // Forward the write in flight when the read hits the same entry.
   always_comb begin
      rd_data = rd_data_arr;
      if (wr_en && (rd_addr == wr_addr)) begin
         rd_data = wr_data;
      end
   end
`else
   // Read data passes straight through; rd_addr only drives the array.
   logic unused_rd_addr;
   assign unused_rd_addr = ^rd_addr;
   assign rd_data        = rd_data_arr;
`endif

endmodule

// File: tb/tb_arf054b256e1r1w0cbbeheaa4acw_wr_arb.sv
// Bench for the register-file write arbiter (built with CWIDTH=4 to reach saturation).
module tb_arf054b256e1r1w0cbbeheaa4acw_wr_arb;

   localparam int unsigned DW = 54;
   localparam int unsigned AW = 8;
   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_vld, b_vld, wr_stall;
   logic          a_rdy, b_rdy, wr_en;
   logic [AW-1:0] a_addr, b_addr, wr_addr, rd_addr;
   logic [DW-1:0] a_data, b_data, wr_data, rd_data_arr, rd_data;
   logic [CW-1:0] wr_cnt;

   int checks   = 0;
   int failures = 0;

   // Bench-side model
   wr_t           q[$];
   logic          m_last_b;
   int            m_cnt;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          ga, gb;
   int            a_idx, b_idx;

   arf054b256e1r1w0cbbeheaa4acw_wr_arb #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_vld(a_vld), .a_rdy(a_rdy), .a_addr(a_addr), .a_data(a_data),
      .b_vld(b_vld), .b_rdy(b_rdy), .b_addr(b_addr), .b_data(b_data),
      .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data_arr(rd_data_arr), .rd_data(rd_data),
      .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, check grant, push expectation, cross the edge, check write.
   task automatic cyc(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic st, output logic oga, output logic ogb);
      logic ea, eb;
      wr_t  e;
      a_vld = av; a_addr = aa; a_data = ad;
      b_vld = bv; b_addr = ba; b_data = bd;
      wr_stall = st;
      #2;
      ea = av & ~st & (~bv | m_last_b);
      eb = bv & ~st & (~av | ~m_last_b);
      chk("a_rdy", 64'(a_rdy), 64'(ea));
      chk("b_rdy", 64'(b_rdy), 64'(eb));
      if (ea) begin
         q.push_back('{addr: aa, data: ad});
         m_last_b = 1'b0;
      end else if (eb) begin
         q.push_back('{addr: ba, data: bd});
         m_last_b = 1'b1;
      end
      oga = ea;
      ogb = eb;
      @(posedge clk);
      #1;
      chk("wr_cnt", 64'(wr_cnt), 64'(m_cnt));
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("wr_en", 64'(wr_en), 64'd1);
         chk("wr_addr", 64'(wr_addr), 64'(e.addr));
         chk("wr_data", 64'(wr_data), 64'(e.data));
         m_addr = e.addr;
         m_data = e.data;
         if (m_cnt < 15) m_cnt++;
      end else begin
         chk("wr_en_idle", 64'(wr_en), 64'd0);
         chk("wr_addr_hold", 64'(wr_addr), 64'(m_addr));
         chk("wr_data_hold", 64'(wr_data), 64'(m_data));
      end
   endtask

   task automatic idle();
      logic x, y;
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, x, y);
   endtask

   initial begin
      rst_n = 1'b0;
      a_vld = 1'b0; b_vld = 1'b0; wr_stall = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      rd_addr = '0; rd_data_arr = '0;
      m_last_b = 1'b1; m_cnt = 0; m_addr = '0; m_data = '0;
      a_idx = 0; b_idx = 0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      a_vld = 1'b1; b_vld = 1'b1;
      #1;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
      chk("rst_a_rdy", 64'(a_rdy), 64'd0);
      chk("rst_b_rdy", 64'(b_rdy), 64'd0);
      a_vld = 1'b0; b_vld = 1'b0;
      rst_n = 1'b1;

      // Single requester A, then idle to see the count
      cyc(1'b1, 8'h10, 54'h2A_AAAA_AAAA_AAAA, 1'b0, '0, '0, 1'b0, ga, gb);
      idle();
      chk("single_cnt", 64'(wr_cnt), 64'd1);

      // Single requester B
      cyc(1'b0, '0, '0, 1'b1, 8'hC3, 54'h15_5555_0000_1234, 1'b0, ga, gb);
      idle();

      // Stall three cycles with A waiting, then release
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 8'h33, 54'h0_0BAD_F00D, 1'b0, '0, '0, 1'b1, ga, gb);
      cyc(1'b1, 8'h33, 54'h0_0BAD_F00D, 1'b0, '0, '0, 1'b0, ga, gb);
      chk("stall_release_grant", 64'(ga), 64'd1);
      idle();

      // Stall while a write is in flight: it completes, nothing new is granted
      cyc(1'b1, 8'h44, 54'h1111, 1'b0, '0, '0, 1'b0, ga, gb);
      cyc(1'b1, 8'h45, 54'h2222, 1'b1, 8'h46, 54'h3333, 1'b1, ga, gb);
      cyc(1'b1, 8'h45, 54'h2222, 1'b1, 8'h46, 54'h3333, 1'b1, ga, gb);

      // Same address from both: winner then loser
      cyc(1'b1, 8'h55, 54'hAAAA, 1'b1, 8'h55, 54'hBBBB, 1'b0, ga, gb);
      cyc(ga ? 1'b0 : 1'b1, 8'h55, 54'hAAAA, gb ? 1'b0 : 1'b1, 8'h55, 54'hBBBB, 1'b0, ga, gb);
      chk("same_addr_second", 64'({ga, gb}) != 64'd0 ? 64'd1 : 64'd0, 64'd1);
      idle();

      // Read during the write cycle
      cyc(1'b1, 8'h80, 54'h3F, 1'b0, '0, '0, 1'b0, ga, gb);
      rd_addr = 8'h80; rd_data_arr = '0;
      #1;
`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
      chk("bypass_hit", 64'(rd_data), 64'h3F);
`else
      chk("bypass_off", 64'(rd_data), 64'h0);
`endif
      rd_addr = 8'h81; rd_data_arr = 54'h123;
      #1;
      chk("bypass_miss", 64'(rd_data), 64'h123);
      rd_addr = '0; rd_data_arr = '0;

      // Reset mid-write: strobe, count and grants drop at once
      idle();
      cyc(1'b1, 8'h66, 54'h6666, 1'b0, '0, '0, 1'b0, ga, gb);
      a_vld = 1'b1; b_vld = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", 64'(wr_en), 64'd0);
      chk("midrst_wr_cnt", 64'(wr_cnt), 64'd0);
      chk("midrst_a_rdy", 64'(a_rdy), 64'd0);
      chk("midrst_b_rdy", 64'(b_rdy), 64'd0);
      q.delete();
      m_last_b = 1'b1; m_cnt = 0; m_addr = '0; m_data = '0;
      #2;
      rst_n = 1'b1;

      // Contention: six cycles, both valid, losers hold their request
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, AW'(8'h20 + a_idx), DW'(64'h100 + a_idx),
             1'b1, AW'(8'h40 + b_idx), DW'(64'h200 + b_idx), 1'b0, ga, gb);
         chk("cont_seq", 64'({ga, gb}), (i % 2 == 0) ? 64'd2 : 64'd1);
         if (ga) a_idx++;
         if (gb) b_idx++;
      end
      idle();
      chk("cont_cnt", 64'(wr_cnt), 64'd6);

      // Saturation of the 4-bit counter
      for (int i = 0; i < 20; i++)
         cyc(1'b1, AW'(i), DW'(i), 1'b0, '0, '0, 1'b0, ga, gb);
      idle();
      idle();
      chk("sat_cnt", 64'(wr_cnt), 64'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
